// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_arbiter_pkg: MemOp encodings, bus width
// and arbiter state encodings shared by the arbiter.
package riscv_mem_arbiter_pkg;

  localparam int MEMOP_BUS_W = 3;

  typedef logic [MEMOP_BUS_W-1:0] memop_t;

  localparam memop_t MEMOP_B  = 3'b000;
  localparam memop_t MEMOP_H  = 3'b001;
  localparam memop_t MEMOP_W  = 3'b010;
  localparam memop_t MEMOP_BU = 3'b100;
  localparam memop_t MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY_IF,
    ST_BUSY_LS,
    ST_RESP
  } arb_state_t;

  function automatic logic memop_is_b(memop_t op);
    return op[1:0] == MEMOP_B[1:0];
  endfunction

  function automatic logic memop_is_h(memop_t op);
    return op[1:0] == MEMOP_H[1:0];
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: single-port memory bus,
// master = arbiter side, slave = memory side.
interface riscv_mem_arbiter_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/riscv_mem_arbiter_lsu_align.sv
// riscv_lsu_align: store lane shifting and load extension.
// Macro MEM_ALIGN_CHECK_EN enables the misalign flag.
module riscv_lsu_align
  import riscv_mem_arbiter_pkg::*;
(
  input  memop_t      memop,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        sx;

  assign ld_b = 8'(ld_data >> {off, 3'b000});
  assign ld_h = 16'(ld_data >> {off[1], 4'b0000});
  assign sx   = ~memop[2];

  // size decode: byte, half, everything else is a word
  always_comb begin
    wstrb = 4'b1111;
    wdata = st_data;
    rdata = ld_data;
    unique case (1'b1)
      memop_is_b(memop): begin
        wstrb = 4'b0001 << off;
        wdata = {4{st_data[7:0]}};
        rdata = {{24{sx & ld_b[7]}}, ld_b};
      end
      memop_is_h(memop): begin
        wstrb = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
        rdata = {{16{sx & ld_h[15]}}, ld_h};
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = memop_is_b(memop) ? 1'b0 :
                    memop_is_h(memop) ? off[0] : |off;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: IFU/LSU arbiter for one memory port.
// Macro MEM_ALIGN_CHECK_EN rejects misaligned LSU accesses.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int MAX_LSU_BURST = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  memop_t      lsu_memop,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  riscv_mem_arbiter_if.master mem,
  output logic        stall_if,
  output logic        stall_mem
);

  arb_state_t  state, state_nxt;
  logic [3:0]  burst_cnt;
  logic [7:0]  tmo_cnt;
  memop_t      ls_op;
  logic [1:0]  ls_off;
  logic        ls_we;
  logic        grant_ls, grant_if;
  logic        tmo_hit, busy_done;
  memop_t      al_op;
  logic [1:0]  al_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_rdata;
  logic        ls_bad;

  assign grant_ls = lsu_req &
    ~(ifu_req & (burst_cnt == 4'(MAX_LSU_BURST)));
  assign grant_if = ifu_req & ~grant_ls;

  assign tmo_hit   = tmo_cnt == 8'(TIMEOUT - 1);
  assign busy_done = mem.mem_ready | tmo_hit;

  assign al_op  = (state == ST_IDLE) ? lsu_memop : ls_op;
  assign al_off = (state == ST_IDLE) ? lsu_addr[1:0] : ls_off;

  assign stall_if  = ifu_req & ~ifu_valid;
  assign stall_mem = lsu_req & ~lsu_valid;

  riscv_lsu_align u_align (
    .memop    (al_op),
    .off      (al_off),
    .st_data  (lsu_wdata),
    .ld_data  (mem.mem_rdata),
    .wstrb    (al_wstrb),
    .wdata    (al_wdata),
    .rdata    (al_rdata),
    .misalign (ls_bad)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state: grant in IDLE, finish on ready/timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (grant_ls)
          state_nxt = ls_bad ? ST_RESP : ST_BUSY_LS;
        else if (grant_if)
          state_nxt = ST_BUSY_IF;
      end
      ST_BUSY_IF,
      ST_BUSY_LS: if (busy_done) state_nxt = ST_RESP;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // anti-starvation burst counter and access watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (!ifu_req || grant_if)
          burst_cnt <= '0;
        else if (grant_ls && !ls_bad)
          burst_cnt <= burst_cnt + 4'd1;
      end
      if (state == ST_BUSY_IF || state == ST_BUSY_LS)
        tmo_cnt <= tmo_cnt + 8'd1;
      else
        tmo_cnt <= '0;
    end
  end

  // registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= '0;
      mem.mem_wdata <= '0;
      ifu_valid     <= 1'b0;
      ifu_rdata     <= '0;
      ifu_err       <= 1'b0;
      lsu_valid     <= 1'b0;
      lsu_rdata     <= '0;
      lsu_err       <= 1'b0;
      ls_op         <= '0;
      ls_off        <= '0;
      ls_we         <= 1'b0;
    end else begin
      ifu_valid <= 1'b0;
      lsu_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant_ls) begin
            ls_op  <= lsu_memop;
            ls_off <= lsu_addr[1:0];
            ls_we  <= lsu_we;
            if (ls_bad) begin
              lsu_valid <= 1'b1;
              lsu_err   <= 1'b1;
              lsu_rdata <= '0;
            end else begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= lsu_we;
              mem.mem_addr  <= lsu_addr & 32'hFFFF_FFFC;
              mem.mem_wstrb <= lsu_we ? al_wstrb : 4'b0000;
              mem.mem_wdata <= al_wdata;
            end
          end else if (grant_if) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= ifu_addr & 32'hFFFF_FFFC;
            mem.mem_wstrb <= 4'b0000;
            mem.mem_wdata <= '0;
          end
        end
        ST_BUSY_IF: begin
          if (busy_done) begin
            mem.mem_req <= 1'b0;
            ifu_valid   <= 1'b1;
            ifu_err     <= ~mem.mem_ready;
            ifu_rdata   <= mem.mem_ready ? mem.mem_rdata : '0;
          end
        end
        ST_BUSY_LS: begin
          if (busy_done) begin
            mem.mem_req <= 1'b0;
            lsu_valid   <= 1'b1;
            lsu_err     <= ~mem.mem_ready;
            lsu_rdata   <= (mem.mem_ready && !ls_we) ? al_rdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: vector table, corner sequences
// and randomized traffic against a byte-level memory model.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, ifu_valid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req, lsu_we, lsu_valid, lsu_err;
  logic [2:0]  lsu_memop;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        stall_if, stall_mem;

  riscv_mem_arbiter_if mem_if ();

  riscv_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ifu_req   (ifu_req),
    .ifu_addr  (ifu_addr),
    .ifu_valid (ifu_valid),
    .ifu_rdata (ifu_rdata),
    .ifu_err   (ifu_err),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .lsu_memop (lsu_memop),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_valid (lsu_valid),
    .lsu_rdata (lsu_rdata),
    .lsu_err   (lsu_err),
    .mem       (mem_if),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] dmem [0:255];
  logic [7:0]  ref_b [0:1023];
  int          rsp_lat = 0;
  bit          rsp_never = 1'b0;
  int          busy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // memory device: answers after rsp_lat waiting cycles
  initial begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_if.mem_req && !rsp_never && busy_cnt >= rsp_lat) begin
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = dmem[mem_if.mem_addr[9:2]];
        if (mem_if.mem_we)
          for (int k = 0; k < 4; k++)
            if (mem_if.mem_wstrb[k])
              dmem[mem_if.mem_addr[9:2]][8*k +: 8] =
                mem_if.mem_wdata[8*k +: 8];
        busy_cnt = 0;
      end else begin
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = $urandom;
        busy_cnt = mem_if.mem_req ? busy_cnt + 1 : 0;
      end
    end
  end

  logic [31:0] r_rd, r_mwd;
  logic        r_err, r_mwe, r_seen;
  logic [3:0]  r_strb;
  int          r_lat, r_nreq;

  task automatic do_lsu(input logic we, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd);
    bit done = 0;
    lsu_req = 1'b1; lsu_we = we; lsu_memop = op;
    lsu_addr = a; lsu_wdata = wd;
    r_rd = '0; r_err = 0; r_strb = '0; r_mwd = '0;
    r_mwe = 0; r_seen = 0; r_lat = 0;
    while (!done && r_lat < 200) begin
      @(posedge clk); #2; r_lat++;
      if (mem_if.mem_req) begin
        r_seen = 1; r_strb = mem_if.mem_wstrb;
        r_mwd = mem_if.mem_wdata; r_mwe = mem_if.mem_we;
      end
      if (lsu_valid) begin
        r_rd = lsu_rdata; r_err = lsu_err; done = 1;
      end
    end
    if (!done) chk("lsu_no_valid", 32'd0, 32'd1);
    lsu_req = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic do_ifu(input logic [31:0] a);
    bit done = 0;
    ifu_req = 1'b1; ifu_addr = a;
    r_rd = '0; r_err = 0; r_lat = 0; r_nreq = 0;
    while (!done && r_lat < 200) begin
      @(posedge clk); #2; r_lat++;
      if (mem_if.mem_req) r_nreq++;
      if (ifu_valid) begin
        r_rd = ifu_rdata; r_err = ifu_err; done = 1;
      end
    end
    if (!done) chk("ifu_no_valid", 32'd0, 32'd1);
    ifu_req = 1'b0;
    @(posedge clk); #2;
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
  endfunction

  // reference: byte-addressed little-endian memory semantics
  task automatic model_lsu(input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
    int     a, sz, base;
    longint v;
    a  = int'(addr);
    sz = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    base = a - (a % sz);
    rd = '0; err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (a % sz != 0) err = 1'b1;
`endif
    if (!err) begin
      if (we) begin
        for (int k = 0; k < sz; k++)
          ref_b[base+k] = 8'(wd >> (8*k));
      end else begin
        v = 0;
        for (int k = 0; k < sz; k++)
          v += longint'(ref_b[base+k]) << (8*k);
        if (!op[2] && sz < 4 && v >= (longint'(1) << (8*sz-1)))
          v -= longint'(1) << (8*sz);
        rd = 32'(v);
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    logic [3:0]  xstrb;
    logic [31:0] xwd;
    logic [31:0] xrd;
  } vec_t;

  vec_t tbl [13];

  logic [31:0] exp_i, exp_l;
  logic        exp_le;
  logic [5:0]  ord;
  int          n, cyc, bad;
  bit          pend_i, pend_l, seen_if;
  logic [2:0]  ops [8];

  initial begin
    tbl[0]  = '{0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h0, 32'hDEADBEEF};
    tbl[1]  = '{0, 3'b000, 32'h103, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'hFFFFFF80};
    tbl[2]  = '{0, 3'b100, 32'h103, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'h00000080};
    tbl[3]  = '{0, 3'b001, 32'h102, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'hFFFF8011};
    tbl[4]  = '{0, 3'b101, 32'h100, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'h00002233};
    tbl[5]  = '{0, 3'b000, 32'h101, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'h00000022};
    tbl[6]  = '{1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0};
    tbl[7]  = '{1, 3'b000, 32'h101, 32'h123456EF, 32'h0, 4'b0010, 32'hEFEFEFEF, 32'h0};
    tbl[8]  = '{1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0};
    tbl[9]  = '{0, 3'b011, 32'h108, 32'h0, 32'h11223344, 4'b0000, 32'h0, 32'h11223344};
    tbl[10] = '{0, 3'b110, 32'h10C, 32'h0, 32'h55667788, 4'b0000, 32'h0, 32'h55667788};
    tbl[11] = '{1, 3'b000, 32'h100, 32'h000000AB, 32'h0, 4'b0001, 32'hABABABAB, 32'h0};
    tbl[12] = '{0, 3'b001, 32'h100, 32'h0, 32'h1234F0F0, 4'b0000, 32'h0, 32'hFFFFF0F0};
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100;
    ops[4] = 3'b101; ops[5] = 3'b011; ops[6] = 3'b110; ops[7] = 3'b111;

    for (int i = 0; i < 256; i++) dmem[i] = '0;
    rst = 1'b1;
    ifu_req = 0; ifu_addr = '0;
    lsu_req = 0; lsu_we = 0; lsu_memop = '0;
    lsu_addr = '0; lsu_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
    chk("rst_valids", {30'd0, ifu_valid, lsu_valid}, 32'd0);
    chk("rst_errs", {30'd0, ifu_err, lsu_err}, 32'd0);
    chk("rst_ifu_rdata", ifu_rdata, 32'd0);
    chk("rst_lsu_rdata", lsu_rdata, 32'd0);
    chk("rst_stalls", {30'd0, stall_if, stall_mem}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    // vector table, zero-wait memory
    rsp_lat = 0;
    for (int i = 0; i < 13; i++) begin
      if (!tbl[i].we) dmem[tbl[i].addr[9:2]] = tbl[i].mrd;
      do_lsu(tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wd);
      chk($sformatf("v%0d_strb", i), 32'(r_strb), 32'(tbl[i].xstrb));
      chk($sformatf("v%0d_we", i), 32'(r_mwe), 32'(tbl[i].we));
      chk($sformatf("v%0d_rdata", i), r_rd, tbl[i].xrd);
      chk($sformatf("v%0d_err", i), 32'(r_err), 32'd0);
      chk($sformatf("v%0d_lat", i), 32'(r_lat), 32'd2);
      if (tbl[i].we)
        chk($sformatf("v%0d_wdata", i), r_mwd, tbl[i].xwd);
    end

    // IFU fetch
    dmem[3] = 32'h00A00093;
    do_ifu(32'h0000000C);
    chk("ifu_rdata", r_rd, 32'h00A00093);
    chk("ifu_err", 32'(r_err), 32'd0);
    chk("ifu_lat", 32'(r_lat), 32'd2);

    // both held: four LSU grants, then one IFU grant
    ord = '0; n = 0; cyc = 0; bad = 0; seen_if = 0;
    ifu_req = 1; ifu_addr = 32'h0;
    lsu_req = 1; lsu_we = 0; lsu_memop = 3'b010; lsu_addr = 32'h100;
    while (n < 6 && cyc < 100) begin
      @(posedge clk); #2; cyc++;
      if (!seen_if && !ifu_valid && stall_if !== 1'b1) bad++;
      if (lsu_valid) begin ord = {ord[4:0], 1'b1}; n++; end
      if (ifu_valid) begin
        ord = {ord[4:0], 1'b0}; n++; seen_if = 1;
        chk("stall_if_at_valid", 32'(stall_if), 32'd0);
      end
    end
    chk("burst_order", 32'(ord), 32'b111101);
    chk("burst_count", 32'(n), 32'd6);
    chk("stall_if_held", 32'(bad), 32'd0);
    ifu_req = 0; lsu_req = 0;
    @(posedge clk); #2;

    // watchdog on a fetch that never completes
    rsp_never = 1;
    do_ifu(32'h40);
    chk("tmo_err", 32'(r_err), 32'd1);
    chk("tmo_rdata", r_rd, 32'd0);
    chk("tmo_req_cycles", 32'(r_nreq), 32'd64);
    rsp_never = 0;

    // ready on the last allowed cycle completes normally
    dmem[17] = 32'h13579BDF;
    rsp_lat = 63;
    do_ifu(32'h44);
    chk("lim_err", 32'(r_err), 32'd0);
    chk("lim_rdata", r_rd, 32'h13579BDF);
    rsp_lat = 64;
    do_lsu(0, 3'b010, 32'h100, 32'h0);
    chk("lsu_tmo_err", 32'(r_err), 32'd1);
    chk("lsu_tmo_rdata", r_rd, 32'd0);
    chk("lsu_tmo_lat", 32'(r_lat), 32'd65);
    rsp_lat = 0;

    // reset while BUSY_LS drops the access
    rsp_never = 1;
    lsu_req = 1; lsu_we = 0; lsu_memop = 3'b010; lsu_addr = 32'h100;
    repeat (3) begin @(posedge clk); #2; end
    chk("mid_mem_req", 32'(mem_if.mem_req), 32'd1);
    chk("mid_stall_mem", 32'(stall_mem), 32'd1);
    rst = 1;
    @(posedge clk); #2;
    chk("rst_mid_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_mid_valid", 32'(lsu_valid), 32'd0);
    rst = 0; lsu_req = 0; rsp_never = 0;
    bad = 0;
    repeat (5) begin @(posedge clk); #2; if (lsu_valid) bad++; end
    chk("rst_no_valid", 32'(bad), 32'd0);
    dmem[64] = 32'h600DF00D;
    do_lsu(0, 3'b010, 32'h100, 32'h0);
    chk("post_rst_rdata", r_rd, 32'h600DF00D);
    chk("post_rst_lat", 32'(r_lat), 32'd2);

    // misaligned accesses
    dmem[64] = 32'hA1B2C3D4;
`ifdef MEM_ALIGN_CHECK_EN
    do_lsu(0, 3'b010, 32'h101, 32'h0);
    chk("mis_w_seen", 32'(r_seen), 32'd0);
    chk("mis_w_err", 32'(r_err), 32'd1);
    chk("mis_w_rdata", r_rd, 32'd0);
    chk("mis_w_lat", 32'(r_lat), 32'd1);
    do_lsu(0, 3'b001, 32'h103, 32'h0);
    chk("mis_h_err", 32'(r_err), 32'd1);
    chk("mis_h_seen", 32'(r_seen), 32'd0);
`else
    do_lsu(0, 3'b010, 32'h101, 32'h0);
    chk("mis_w_rdata", r_rd, 32'hA1B2C3D4);
    chk("mis_w_err", 32'(r_err), 32'd0);
    do_lsu(0, 3'b001, 32'h103, 32'h0);
    chk("mis_h_rdata", r_rd, 32'hFFFFA1B2);
    do_lsu(0, 3'b101, 32'h101, 32'h0);
    chk("mis_hu_rdata", r_rd, 32'h0000C3D4);
`endif

    // randomized concurrent traffic, disjoint IFU/LSU regions
    for (int i = 0; i < 256; i++) begin
      dmem[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = dmem[i][8*k +: 8];
    end
    for (int it = 0; it < 200; it++) begin
      logic [31:0] ia, la, wd;
      logic [2:0]  op;
      logic        we;
      rsp_lat = $urandom_range(0, 3);
      pend_i = $urandom_range(0, 1) == 1;
      pend_l = $urandom_range(0, 2) != 0;
      ia = 32'($urandom_range(0, 31)) << 2;
      la = 32'h80 + 32'($urandom_range(0, 127));
      op = ops[$urandom_range(0, 7)];
      we = $urandom_range(0, 1) == 1;
      wd = $urandom;
      exp_i = ref_word(int'(ia));
      exp_l = '0; exp_le = 0;
      if (pend_l) model_lsu(we, op, la, wd, exp_l, exp_le);
      ifu_req = pend_i; ifu_addr = ia;
      lsu_req = pend_l; lsu_we = we; lsu_memop = op;
      lsu_addr = la; lsu_wdata = wd;
      cyc = 0;
      while ((pend_i || pend_l) && cyc < 300) begin
        @(posedge clk); #2; cyc++;
        if (ifu_valid) begin
          if (!pend_i) chk("rnd_ifu_spurious", 32'd1, 32'd0);
          chk("rnd_ifu_rdata", ifu_rdata, exp_i);
          chk("rnd_ifu_err", 32'(ifu_err), 32'd0);
          ifu_req = 0; pend_i = 0;
        end
        if (lsu_valid) begin
          if (!pend_l) chk("rnd_lsu_spurious", 32'd1, 32'd0);
          chk("rnd_lsu_rdata", lsu_rdata, exp_l);
          chk("rnd_lsu_err", 32'(lsu_err), 32'(exp_le));
          lsu_req = 0; pend_l = 0;
        end
      end
      if (pend_i || pend_l) chk("rnd_done", 32'd0, 32'd1);
      ifu_req = 0; lsu_req = 0;
      @(posedge clk); #2;
    end
    for (int i = 0; i < 64; i++)
      chk($sformatf("mem_word_%0d", i), dmem[i], ref_word(4*i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
